// File: rtl/lcd_hex_writer_pkg.sv
// Shared definitions for the HD44780 hex writer: command bytes, character
// constants, FSM encodings and the nibble-to-ASCII helper.
package lcd_hex_writer_pkg;

    // HD44780 command bytes (8-bit interface, 2 lines, 5x8 font)
    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    // Fixed text on line 1
    localparam logic [7:0] CHAR_S  = 8'h53;
    localparam logic [7:0] CHAR_EQ = 8'h3D;

    // Number of bytes in the power-up init sequence
    localparam logic [2:0] INIT_LEN = 3'd4;

    // Sequencing FSM states
    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_INIT  = 3'd1,
        ST_IDLE  = 3'd2,
        ST_ADDR1 = 3'd3,
        ST_LINE1 = 3'd4,
        ST_ADDR2 = 3'd5,
        ST_LINE2 = 3'd6,
        ST_DONE  = 3'd7
    } lcd_state_t;

    // Byte transmitter phases
    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_SETUP  = 2'd1,
        TX_STROBE = 2'd2,
        TX_WAIT   = 2'd3
    } tx_phase_t;

    // Nibble to uppercase ASCII hex digit
    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        logic [7:0] wide;
        wide = {4'h0, nib};
        if (nib < 4'd10) begin
            return 8'h30 + wide;
        end
        return 8'h37 + wide;
    endfunction

    // Init command for a given position in the power-up sequence
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    return LCD_FUNC_SET;
            3'd1:    return LCD_DISP_ON;
            3'd2:    return LCD_CLEAR;
            default: return LCD_ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/lcd_hex_writer_if.sv
// Host-side control/data and LCD pin bundle of the hex writer.
// The writer itself uses the slave view; whoever drives it uses master.
interface lcd_hex_writer_if;
    logic        iEN;
    logic [7:0]  iSEL;
    logic [31:0] iVALUE;
    logic        oBUSY;
    logic        oFRAME_DONE;
    logic [7:0]  LCD_DATA;
    logic        LCD_RS;
    logic        LCD_RW;
    logic        LCD_EN;

    modport master (
        output iEN, iSEL, iVALUE,
        input  oBUSY, oFRAME_DONE, LCD_DATA, LCD_RS, LCD_RW, LCD_EN
    );

    modport slave (
        input  iEN, iSEL, iVALUE,
        output oBUSY, oFRAME_DONE, LCD_DATA, LCD_RS, LCD_RW, LCD_EN
    );
endinterface

// File: rtl/lcd_hex_writer_byte_tx.sv
// Single-byte LCD write: one setup cycle with data/RS on the bus and EN low,
// EN high for EN_CYCLES, then an idle wait (longer after the clear command).
// ready is high when idle or on the last wait cycle, so a start presented in
// the done cycle chains the next byte with no dead cycle between them.
module lcd_hex_writer_byte_tx
    import lcd_hex_writer_pkg::*;
#(
    parameter int EN_CYCLES = 16,
    parameter int CMD_WAIT  = 2000,
    parameter int CLR_WAIT  = 82000,
    parameter int WAIT_W    = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       rs_in,
    output logic       ready,
    output logic       done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en
);

    localparam logic [WAIT_W-1:0] EN_LAST  = WAIT_W'(EN_CYCLES - 1);
    localparam logic [WAIT_W-1:0] CMD_LAST = WAIT_W'(CMD_WAIT - 1);
    localparam logic [WAIT_W-1:0] CLR_LAST = WAIT_W'(CLR_WAIT - 1);

    tx_phase_t         phase_reg, phase_next;
    logic [WAIT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]        data_reg, data_next;
    logic              rs_reg, rs_next;
    logic              en_reg, en_next;
    logic              clr_reg, clr_next;
    logic [WAIT_W-1:0] wait_last;

    // State and datapath registers; reset drops EN on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_reg <= TX_IDLE;
            cnt_reg   <= '0;
            data_reg  <= 8'h00;
            rs_reg    <= 1'b0;
            en_reg    <= 1'b0;
            clr_reg   <= 1'b0;
        end else begin
            phase_reg <= phase_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            rs_reg    <= rs_next;
            en_reg    <= en_next;
            clr_reg   <= clr_next;
        end
    end

    // Next-state logic: accept a new byte when ready, else walk the phases
    always_comb begin
        phase_next = phase_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        rs_next    = rs_reg;
        en_next    = en_reg;
        clr_next   = clr_reg;
        if (start && ready) begin
            phase_next = TX_SETUP;
            cnt_next   = '0;
            data_next  = din;
            rs_next    = rs_in;
            en_next    = 1'b0;
            clr_next   = !rs_in && (din == LCD_CLEAR);
        end else begin
            case (phase_reg)
                TX_SETUP: begin
                    phase_next = TX_STROBE;
                    en_next    = 1'b1;
                    cnt_next   = '0;
                end
                TX_STROBE: begin
                    if (cnt_reg == EN_LAST) begin
                        phase_next = TX_WAIT;
                        en_next    = 1'b0;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + WAIT_W'(1);
                    end
                end
                TX_WAIT: begin
                    if (done) begin
                        phase_next = TX_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decoded from registered state only
    always_comb begin
        wait_last = clr_reg ? CLR_LAST : CMD_LAST;
        done      = (phase_reg == TX_WAIT) && (cnt_reg == wait_last);
        ready     = (phase_reg == TX_IDLE) || done;
    end

    assign lcd_data = data_reg;
    assign lcd_rs   = rs_reg;
    assign lcd_en   = en_reg;

endmodule

// File: rtl/lcd_hex_writer.sv
// HD44780 16x2 hex writer. Line 1 shows "S=" and the select code, line 2 the
// 32-bit value as 8 uppercase hex digits. After the power-up wait and init
// sequence, frames are rewritten back to back for as long as iEN is high.
// The FSM advances when a byte is handed to the transmitter, so the next byte
// is already queued when the previous one finishes its wait.
module lcd_hex_writer
    import lcd_hex_writer_pkg::*;
#(
    parameter int EN_CYCLES = 16,
    parameter int CMD_WAIT  = 2000,
    parameter int CLR_WAIT  = 82000,
    parameter int INIT_WAIT = 800000
) (
    input  logic iCLK,
    input  logic iRST_N,
    lcd_hex_writer_if.slave bus
);

    localparam int WAIT_MAX = (CLR_WAIT > INIT_WAIT) ? CLR_WAIT : INIT_WAIT;
    localparam int WAIT_W   = $clog2(WAIT_MAX) + 1;
    localparam logic [WAIT_W-1:0] PWR_LAST = WAIT_W'(INIT_WAIT - 1);

    lcd_state_t        state_reg, state_next;
    logic [WAIT_W-1:0] pwr_cnt_reg, pwr_cnt_next;
    logic [2:0]        init_idx_reg, init_idx_next;
    logic [1:0]        char_idx_reg, char_idx_next;
    logic [2:0]        nib_reg, nib_next;
    logic [7:0]        sel_reg, sel_next;
    logic [31:0]       value_reg, value_next;
    logic              frame_done_reg, frame_done_next;

    logic              tx_start;
    logic [7:0]        tx_byte;
    logic              tx_rs;
    logic              tx_ready;
    logic              tx_done;
    logic [7:0]        lcd_data;
    logic              lcd_rs;
    logic              lcd_en;

    // Line-2 characters, most significant nibble first
    logic [7:0]        value_chr [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_value_chr
            assign value_chr[gi] = hex2ascii(value_reg[(7 - gi) * 4 +: 4]);
        end
    endgenerate

    // FSM state register
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_reg <= ST_PWRUP;
        end else begin
            state_reg <= state_next;
        end
    end

    // Counters, frame input latches and the frame-done pulse
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            pwr_cnt_reg    <= '0;
            init_idx_reg   <= 3'd0;
            char_idx_reg   <= 2'd0;
            nib_reg        <= 3'd0;
            sel_reg        <= 8'h00;
            value_reg      <= 32'h0;
            frame_done_reg <= 1'b0;
        end else begin
            pwr_cnt_reg    <= pwr_cnt_next;
            init_idx_reg   <= init_idx_next;
            char_idx_reg   <= char_idx_next;
            nib_reg        <= nib_next;
            sel_reg        <= sel_next;
            value_reg      <= value_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // Next-state logic: sending states advance on each accepted byte
    always_comb begin
        state_next      = state_reg;
        pwr_cnt_next    = pwr_cnt_reg;
        init_idx_next   = init_idx_reg;
        char_idx_next   = char_idx_reg;
        nib_next        = nib_reg;
        sel_next        = sel_reg;
        value_next      = value_reg;
        frame_done_next = 1'b0;
        case (state_reg)
            ST_PWRUP: begin
                if (pwr_cnt_reg == PWR_LAST) begin
                    state_next   = ST_INIT;
                    pwr_cnt_next = '0;
                end else begin
                    pwr_cnt_next = pwr_cnt_reg + WAIT_W'(1);
                end
            end
            ST_INIT: begin
                // Stay until the last init byte has finished its wait
                if (init_idx_reg == INIT_LEN) begin
                    if (tx_done) begin
                        state_next    = ST_IDLE;
                        init_idx_next = 3'd0;
                    end
                end else if (tx_ready) begin
                    init_idx_next = init_idx_reg + 3'd1;
                end
            end
            ST_IDLE: begin
                if (bus.iEN) begin
                    state_next = ST_ADDR1;
                    sel_next   = bus.iSEL;
                    value_next = bus.iVALUE;
                end
            end
            ST_ADDR1: begin
                if (tx_ready) begin
                    state_next    = ST_LINE1;
                    char_idx_next = 2'd0;
                end
            end
            ST_LINE1: begin
                if (tx_ready) begin
                    char_idx_next = char_idx_reg + 2'd1;
                    if (char_idx_reg == 2'd3) begin
                        state_next = ST_ADDR2;
                    end
                end
            end
            ST_ADDR2: begin
                if (tx_ready) begin
                    state_next = ST_LINE2;
                end
            end
            ST_LINE2: begin
                // The 3-bit counter wraps 7 -> 0 exactly as LINE2 is left
                if (tx_ready) begin
                    nib_next = nib_reg + 3'd1;
                    if (nib_reg == 3'd7) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (tx_done) begin
                    state_next      = ST_IDLE;
                    frame_done_next = 1'b1;
                end
            end
            default: state_next = ST_PWRUP;
        endcase
    end

    // Output logic: byte selection and transmitter start
    always_comb begin
        tx_start = 1'b0;
        tx_byte  = 8'h00;
        tx_rs    = 1'b0;
        case (state_reg)
            ST_INIT: begin
                tx_start = tx_ready && (init_idx_reg != INIT_LEN);
                tx_byte  = init_cmd(init_idx_reg);
            end
            ST_ADDR1: begin
                tx_start = tx_ready;
                tx_byte  = LCD_LINE1;
            end
            ST_LINE1: begin
                tx_start = tx_ready;
                tx_rs    = 1'b1;
                case (char_idx_reg)
                    2'd0:    tx_byte = CHAR_S;
                    2'd1:    tx_byte = CHAR_EQ;
                    2'd2:    tx_byte = hex2ascii(sel_reg[7:4]);
                    default: tx_byte = hex2ascii(sel_reg[3:0]);
                endcase
            end
            ST_ADDR2: begin
                tx_start = tx_ready;
                tx_byte  = LCD_LINE2;
            end
            ST_LINE2: begin
                tx_start = tx_ready;
                tx_rs    = 1'b1;
                tx_byte  = value_chr[nib_reg];
            end
            default: ;
        endcase
    end

    lcd_hex_writer_byte_tx #(
        .EN_CYCLES (EN_CYCLES),
        .CMD_WAIT  (CMD_WAIT),
        .CLR_WAIT  (CLR_WAIT),
        .WAIT_W    (WAIT_W)
    ) u_byte_tx (
        .clk      (iCLK),
        .rst_n    (iRST_N),
        .start    (tx_start),
        .din      (tx_byte),
        .rs_in    (tx_rs),
        .ready    (tx_ready),
        .done     (tx_done),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_en   (lcd_en)
    );

    assign bus.LCD_DATA    = lcd_data;
    assign bus.LCD_RS      = lcd_rs;
    assign bus.LCD_EN      = lcd_en;
    assign bus.LCD_RW      = 1'b0;
    assign bus.oBUSY       = (state_reg != ST_IDLE);
    assign bus.oFRAME_DONE = frame_done_reg;

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Directed bench for lcd_hex_writer with short timing parameters.
// A negedge monitor records every EN strobe (data, RS, width, preceding low
// time); the scenario tasks compare those records with hand-written values.
// Low time before a strobe = previous byte's wait + the one-cycle data setup.
module tb_lcd_hex_writer;

    logic clk = 1'b0;
    logic rst_n;

    lcd_hex_writer_if bus ();

    lcd_hex_writer #(
        .EN_CYCLES (2),
        .CMD_WAIT  (4),
        .CLR_WAIT  (8),
        .INIT_WAIT (10)
    ) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] cap_data  [$];
    logic       cap_rs    [$];
    int         cap_gap   [$];
    int         cap_width [$];
    int         low_cnt   = 0;
    int         high_cnt  = 0;
    bit         en_prev   = 1'b0;
    int         fd_cnt    = 0;
    int         rw_bad    = 0;

    // Strobe monitor: one line per byte written to the LCD
    always @(negedge clk) begin
        if (!rst_n) begin
            low_cnt  = 0;
            high_cnt = 0;
            en_prev  = 1'b0;
        end else begin
            if (bus.LCD_RW !== 1'b0) rw_bad++;
            if (bus.oFRAME_DONE === 1'b1) fd_cnt++;
            if (bus.LCD_EN === 1'b1 && !en_prev) begin
                cap_data.push_back(bus.LCD_DATA);
                cap_rs.push_back(bus.LCD_RS);
                cap_gap.push_back(low_cnt);
                high_cnt = 1;
                $display("[%0t] byte %0d: data=%h rs=%b low_before=%0d",
                         $time, cap_data.size() - 1, bus.LCD_DATA, bus.LCD_RS, low_cnt);
            end else if (bus.LCD_EN === 1'b1) begin
                high_cnt++;
            end else if (en_prev) begin
                cap_width.push_back(high_cnt);
                low_cnt = 1;
            end else begin
                low_cnt++;
            end
            en_prev = (bus.LCD_EN === 1'b1);
        end
    end

    task automatic clear_caps();
        cap_data.delete();
        cap_rs.delete();
        cap_gap.delete();
        cap_width.delete();
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cap_data.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_frame_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (bus.oFRAME_DONE === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (bus.oBUSY === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int en_seen;
        rst_n = 1'b0;
        bus.iEN = 1'b0;
        bus.iSEL = 8'h00;
        bus.iVALUE = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.LCD_EN !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", bus.LCD_EN); end
        checks++; if (bus.LCD_RS !== 1'b0) begin errors++; $display("FAIL reset_rs: got %b expected 0", bus.LCD_RS); end
        checks++; if (bus.LCD_DATA !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.LCD_DATA); end
        checks++; if (bus.oBUSY !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", bus.oBUSY); end
        checks++; if (bus.oFRAME_DONE !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", bus.oFRAME_DONE); end
        clear_caps();
        rst_n = 1'b1;
        en_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.LCD_EN !== 1'b0) en_seen++;
        end
        checks++; if (en_seen != 0) begin errors++; $display("FAIL pwrup_quiet: EN high in %0d of first 10 cycles, expected 0", en_seen); end
    endtask

    task automatic test_init(input string tag);
        logic [7:0] exp_cmd [4];
        int         exp_gap [4];
        bit         ok;
        exp_cmd[0] = 8'h38; exp_cmd[1] = 8'h0C; exp_cmd[2] = 8'h01; exp_cmd[3] = 8'h06;
        // 10 power-up cycles + start cycle + setup; then wait+setup per byte
        exp_gap[0] = 12; exp_gap[1] = 5; exp_gap[2] = 5; exp_gap[3] = 9;
        wait_bytes(4, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_count: got %0d bytes expected 4", tag, cap_data.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cap_data[i] !== exp_cmd[i]) begin errors++; $display("FAIL %s_data[%0d]: got %h expected %h", tag, i, cap_data[i], exp_cmd[i]); end
            checks++; if (cap_rs[i] !== 1'b0) begin errors++; $display("FAIL %s_rs[%0d]: got %b expected 0", tag, i, cap_rs[i]); end
            checks++; if (cap_gap[i] != exp_gap[i]) begin errors++; $display("FAIL %s_gap[%0d]: got %0d expected %0d", tag, i, cap_gap[i], exp_gap[i]); end
        end
        wait_idle(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_idle: oBUSY got %b expected 0", tag, bus.oBUSY); end
        checks++; if (cap_width.size() != 4) begin errors++; $display("FAIL %s_strobes: got %0d expected 4", tag, cap_width.size()); end
        for (int i = 0; i < cap_width.size(); i++) begin
            checks++; if (cap_width[i] != 2) begin errors++; $display("FAIL %s_width[%0d]: got %0d expected 2", tag, i, cap_width[i]); end
        end
    endtask

    task automatic test_frame();
        logic [7:0] exp_b [14];
        bit         ok;
        exp_b = '{8'h80, 8'h53, 8'h3D, 8'h33, 8'h41, 8'hC0,
                  8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
        clear_caps();
        fd_cnt = 0;
        bus.iSEL = 8'h3A;
        bus.iVALUE = 32'hDEADBEEF;
        bus.iEN = 1'b1;
        wait_bytes(14, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL frame_count: got %0d bytes expected 14", cap_data.size()); end
        for (int i = 0; i < 14; i++) begin
            checks++; if (cap_data[i] !== exp_b[i]) begin errors++; $display("FAIL frame_data[%0d]: got %h expected %h", i, cap_data[i], exp_b[i]); end
            checks++; if (cap_rs[i] !== ((i == 0 || i == 5) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL frame_rs[%0d]: got %b", i, cap_rs[i]); end
        end
        wait_frame_done(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL frame_done_seen: no oFRAME_DONE pulse, expected one"); end
        @(posedge clk); #1;
        checks++; if (bus.oFRAME_DONE !== 1'b0) begin errors++; $display("FAIL frame_done_width: got %b expected 0", bus.oFRAME_DONE); end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", fd_cnt); end
        clear_caps();
    endtask

    task automatic test_value_change();
        logic [7:0] exp_old [8];
        bit         ok;
        exp_old = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
        wait_bytes(9, 400, ok);
        bus.iVALUE = 32'h0;
        wait_bytes(28, 800, ok);
        checks++; if (!ok) begin errors++; $display("FAIL chg_count: got %0d bytes expected 28", cap_data.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (cap_data[6 + i] !== exp_old[i]) begin errors++; $display("FAIL chg_old[%0d]: got %h expected %h", i, cap_data[6 + i], exp_old[i]); end
            checks++; if (cap_data[20 + i] !== 8'h30) begin errors++; $display("FAIL chg_new[%0d]: got %h expected 30", i, cap_data[20 + i]); end
        end
        checks++; if (cap_data[14] !== 8'h80) begin errors++; $display("FAIL chg_next_addr: got %h expected 80", cap_data[14]); end
    endtask

    task automatic test_en_drop();
        bit ok;
        int en_seen;
        wait_bytes(30, 400, ok);
        bus.iEN = 1'b0;
        wait_bytes(42, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_count: got %0d bytes expected 42", cap_data.size()); end
        checks++; if (cap_data[41] !== 8'h30) begin errors++; $display("FAIL drop_last_char: got %h expected 30", cap_data[41]); end
        wait_frame_done(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_frame_done: no pulse, expected one"); end
        checks++; if (bus.oBUSY !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b expected 0", bus.oBUSY); end
        en_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (bus.LCD_EN !== 1'b0 || bus.oBUSY !== 1'b0) en_seen++;
        end
        checks++; if (en_seen != 0) begin errors++; $display("FAIL drop_quiet: EN/busy active in %0d cycles, expected 0", en_seen); end
        checks++; if (cap_data.size() != 42) begin errors++; $display("FAIL drop_no_more: got %0d bytes expected 42", cap_data.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bus.iEN = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bus.LCD_EN === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_strobe: LCD_EN got 0 expected 1"); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.LCD_EN !== 1'b0) begin errors++; $display("FAIL rstmid_en: got %b expected 0", bus.LCD_EN); end
        checks++; if (bus.oBUSY !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b expected 1", bus.oBUSY); end
        bus.iEN = 1'b0;
        clear_caps();
        rst_n = 1'b1;
        test_init("reinit");
    endtask

    task automatic test_digits();
        logic [7:0] exp_b [14];
        bit         ok;
        exp_b = '{8'h80, 8'h53, 8'h3D, 8'h46, 8'h30, 8'hC0,
                  8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h46};
        clear_caps();
        rw_bad = 0;
        bus.iSEL = 8'hF0;
        bus.iVALUE = 32'h0123456F;
        bus.iEN = 1'b1;
        wait_bytes(14, 400, ok);
        bus.iEN = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL digit_count: got %0d bytes expected 14", cap_data.size()); end
        for (int i = 0; i < 14; i++) begin
            checks++; if (cap_data[i] !== exp_b[i]) begin errors++; $display("FAIL digit_data[%0d]: got %h expected %h", i, cap_data[i], exp_b[i]); end
        end
        checks++; if (cap_gap[7] != 5) begin errors++; $display("FAIL digit_gap: got %0d expected 5", cap_gap[7]); end
        wait_frame_done(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL digit_frame_done: no pulse, expected one"); end
        checks++; if (rw_bad != 0) begin errors++; $display("FAIL rw_low: LCD_RW nonzero in %0d cycles, expected 0", rw_bad); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init("init");
        test_frame();
        test_value_change();
        test_en_drop();
        test_reset_mid();
        test_digits();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
